// File: rtl/pulse_train_gen_if.sv
// Handshake and pulse-output bundle for pulse_train_gen.
// The abort_i line exists only when PULSE_GEN_ABORT_EN is defined.
interface pulse_train_gen_if #(
  parameter int WIDTH = 8
) ();
  logic             start_i;
  logic [WIDTH-1:0] num_cnt_i;
`ifdef PULSE_GEN_ABORT_EN
  logic             abort_i;
`endif
  logic             ready_o;
  logic             busy_o;
  logic             num_o;
  logic             done_o;
  logic [WIDTH-1:0] sent_o;

  // Generator side: takes requests, drives the pulse train and status.
  modport slave (
    input  start_i,
    input  num_cnt_i,
`ifdef PULSE_GEN_ABORT_EN
    input  abort_i,
`endif
    output ready_o,
    output busy_o,
    output num_o,
    output done_o,
    output sent_o
  );

  // Requester side: issues requests and observes the train.
  modport master (
    output start_i,
    output num_cnt_i,
`ifdef PULSE_GEN_ABORT_EN
    output abort_i,
`endif
    input  ready_o,
    input  busy_o,
    input  num_o,
    input  done_o,
    input  sent_o
  );
endinterface

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits exactly N single-cycle pulses on num_o, each followed
// by GAP low cycles, then strobes done_o and reports the pulse count on sent_o.
// Optional feature macro: PULSE_GEN_ABORT_EN (adds abort_i to the interface).
module pulse_train_gen #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  pulse_train_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Gap counter is loaded with GAP-1 on entering LOW and counts down to 0,
  // so LOW lasts exactly GAP cycles.
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t           state;
  logic [WIDTH-1:0] remaining;
  logic [7:0]       gap_cnt;
  logic             ready;
  logic             busy;
  logic             num;
  logic             done;
  logic [WIDTH-1:0] sent;
  logic             abort_req;

`ifdef PULSE_GEN_ABORT_EN
  assign abort_req = bus.abort_i;
`else
  assign abort_req = 1'b0;
`endif

  // Train FSM: every output is a register updated together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      gap_cnt   <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      num       <= 1'b0;
      done      <= 1'b0;
      sent      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            remaining <= bus.num_cnt_i;
            ready     <= 1'b0;
            if (bus.num_cnt_i == '0) begin
              state <= DONE;
              done  <= 1'b1;
              sent  <= '0;
            end else begin
              // sent clears on accept and counts the first pulse at once.
              state <= HIGH;
              busy  <= 1'b1;
              num   <= 1'b1;
              sent  <= WIDTH'(1);
            end
          end
        end
        HIGH: begin
          remaining <= remaining - 1'b1;
          num       <= 1'b0;
          if (abort_req) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state   <= LOW;
            gap_cnt <= GAP_LAST;
          end
        end
        LOW: begin
          if (abort_req) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (gap_cnt == 8'd0) begin
            if (remaining != '0) begin
              state <= HIGH;
              num   <= 1'b1;
              sent  <= sent + 1'b1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          num   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o = ready;
  assign bus.busy_o  = busy;
  assign bus.num_o   = num;
  assign bus.done_o  = done;
  assign bus.sent_o  = sent;

endmodule
